// File: rtl/pheap_lvl_mem_pkg.sv
// Shared pheap types for the level storage responder: entry layout, empty
// constants, memory FSM states and the pair-address helper.
package pheap_lvl_mem_pkg;

   localparam int LEVELS = 8;
   localparam int KEY_W  = 16;
   localparam int VAL_W  = 16;
   localparam int CAP_W  = LEVELS;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   typedef struct packed {
      logic             active;
      logic [CAP_W-1:0] capacity;
      kv_t              kv;
   } entry_t;

   localparam kv_t    KV_EMPTY    = '{key: '1, val: '0};
   localparam entry_t ENTRY_EMPTY = '{active: 1'b0, capacity: '0, kv: KV_EMPTY};

   typedef enum logic {CLEAR, RUN} mem_state_t;

   // Even member of the sibling pair containing addr.
   function automatic logic [LEVELS-1:0] pair_base(input logic [LEVELS-1:0] addr);
      return addr & ~LEVELS'(1);
   endfunction

endpackage

// File: rtl/pheap_lvl_mem_if.sv
// Per-level access bundle between the level managers and the level storage.
interface pheap_lvl_mem_if
   import pheap_lvl_mem_pkg::*;
#(
   parameter int AW = 1
);
   logic          clr;
   logic [AW-1:0] raddrTop;
   entry_t        rTop;
   logic          wenTop;
   logic [AW-1:0] wraddrTop;
   entry_t        wData;
   logic [AW-1:0] raddrPair;
   entry_t        rBotL;
   entry_t        rBotR;
   logic          ready;
   logic          err;

   modport master (
      output clr, raddrTop, wenTop, wraddrTop, wData, raddrPair,
      input  rTop, rBotL, rBotR, ready, err
   );

   modport slave (
      input  clr, raddrTop, wenTop, wraddrTop, wData, raddrPair,
      output rTop, rBotL, rBotR, ready, err
   );
endinterface

// File: rtl/pheap_lvl_mem_ram_2r1w.sv
// Plain synchronous RAM: one write port, one single-entry read port and one
// pair read port returning both siblings. Reads return pre-write content.
module pheap_ram_2r1w #(
   parameter int AW = 1,
   parameter int W  = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata,
   input  logic [AW-1:0] raddr_pair,
   output logic [W-1:0]  rdata_l,
   output logic [W-1:0]  rdata_r
);
   localparam int DEPTH = 2 ** AW;

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata   <= mem[raddr];
      rdata_l <= mem[raddr_pair & ~AW'(1)];
      rdata_r <= mem[raddr_pair | AW'(1)];
   end
endmodule

// File: rtl/pheap_lvl_mem.sv
// Storage responder for one pheap level: post-reset invalidate sweep, top and
// pair reads with write-first forwarding, sticky error on early writes.
module pheap_lvl_mem
   import pheap_lvl_mem_pkg::*;
#(
   parameter  int LEVEL = 2,
   localparam int AW    = LEVEL - 1,
   localparam int DEPTH = 2 ** AW
) (
   input logic            clk,
   input logic            rst_n,
   pheap_lvl_mem_if.slave bus
);
   localparam int W = $bits(entry_t);

   mem_state_t    state, state_nxt;
   logic [AW-1:0] sweep_ptr, sweep_ptr_nxt;
   logic          ready_q, err_q;
   logic          run_wr, ram_we;
   logic [AW-1:0] ram_waddr, pair_l, pair_r;
   entry_t        ram_wdata, ram_top, ram_l, ram_r, wdata_q;
   logic          rd_vld, fwd_top, fwd_l, fwd_r;

   assign pair_l = AW'(pair_base(LEVELS'(bus.raddrPair)));
   assign pair_r = pair_l | AW'(1);

   // clr wins over a same-cycle write, so the write is simply dropped.
   assign run_wr = (state == RUN) && bus.wenTop && !bus.clr;

   always_comb begin
      state_nxt     = state;
      sweep_ptr_nxt = sweep_ptr;
      ram_we        = 1'b0;
      ram_waddr     = bus.wraddrTop;
      ram_wdata     = bus.wData;
      case (state)
         CLEAR: begin
            ram_we        = 1'b1;
            ram_waddr     = sweep_ptr;
            ram_wdata     = ENTRY_EMPTY;
            sweep_ptr_nxt = sweep_ptr + AW'(1);
            if (sweep_ptr == AW'(DEPTH - 1)) state_nxt = RUN;
         end
         RUN:     ram_we = run_wr;
         default: state_nxt = CLEAR;
      endcase
      if (bus.clr) begin
         state_nxt     = CLEAR;
         sweep_ptr_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR;
         sweep_ptr <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep_ptr <= sweep_ptr_nxt;
         ready_q   <= (state_nxt == RUN);
         if (bus.wenTop && !bus.clr && state != RUN) err_q <= 1'b1;
      end
   end

   // Forward flags are registered alongside the RAM read so the mux lines up
   // with the one-cycle read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld  <= 1'b0;
         fwd_top <= 1'b0;
         fwd_l   <= 1'b0;
         fwd_r   <= 1'b0;
         wdata_q <= ENTRY_EMPTY;
      end else begin
         rd_vld  <= (state == RUN);
         fwd_top <= run_wr && (bus.wraddrTop == bus.raddrTop);
         fwd_l   <= run_wr && (bus.wraddrTop == pair_l);
         fwd_r   <= run_wr && (bus.wraddrTop == pair_r);
         wdata_q <= bus.wData;
      end
   end

   pheap_ram_2r1w #(.AW(AW), .W(W)) u_ram (
      .clk        (clk),
      .we         (ram_we),
      .waddr      (ram_waddr),
      .wdata      (ram_wdata),
      .raddr      (bus.raddrTop),
      .rdata      (ram_top),
      .raddr_pair (pair_l),
      .rdata_l    (ram_l),
      .rdata_r    (ram_r)
   );

   assign bus.rTop  = !rd_vld ? ENTRY_EMPTY : fwd_top ? wdata_q : ram_top;
   assign bus.rBotL = !rd_vld ? ENTRY_EMPTY : fwd_l   ? wdata_q : ram_l;
   assign bus.rBotR = !rd_vld ? ENTRY_EMPTY : fwd_r   ? wdata_q : ram_r;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_pheap_lvl_mem.sv
// Directed bench for pheap_lvl_mem at LEVEL=3: sweep timing, forwarding,
// clr priority, sticky err and mid-sweep reset.
module tb_pheap_lvl_mem;
   import pheap_lvl_mem_pkg::*;

   localparam int LEVEL = 3;
   localparam int AW    = LEVEL - 1;
   localparam int DEPTH = 4;
   localparam int W     = $bits(entry_t);

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   pheap_lvl_mem_if #(.AW(AW)) bus ();

   pheap_lvl_mem #(.LEVEL(LEVEL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic          clr;
      logic          wen;
      logic [AW-1:0] waddr;
      entry_t        wdata;
      logic [AW-1:0] raddr;
      logic [AW-1:0] paddr;
      entry_t        exp_top;
      entry_t        exp_l;
      entry_t        exp_r;
      logic          exp_ready;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic entry_t mk(input logic [7:0] cap, input logic [15:0] k, input logic [15:0] v);
      entry_t e;
      e.active      = 1'b1;
      e.capacity    = cap;
      e.kv.key      = k;
      e.kv.val      = v;
      return e;
   endfunction

   function automatic vec_t mv(input logic clr, input logic wen, input logic [AW-1:0] wa,
                               input entry_t wd, input logic [AW-1:0] ra, input logic [AW-1:0] pa,
                               input entry_t et, input entry_t el, input entry_t er, input logic rdy);
      vec_t v;
      v.clr = clr; v.wen = wen; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.paddr = pa;
      v.exp_top = et; v.exp_l = el; v.exp_r = er; v.exp_ready = rdy;
      return v;
   endfunction

   task automatic idle();
      bus.clr = 1'b0; bus.wenTop = 1'b0; bus.wraddrTop = '0; bus.wData = ENTRY_EMPTY;
      bus.raddrTop = '0; bus.raddrPair = '0;
   endtask

   // Counts edges until ready rises; expects exactly DEPTH, with reads blank meanwhile.
   task automatic sweep_wait(input string tag);
      for (int i = 1; i <= DEPTH; i++) begin
         step();
         chk1({tag, "_ready"}, bus.ready, (i == DEPTH));
         if (i < DEPTH) chk({tag, "_rtop_blank"}, bus.rTop, ENTRY_EMPTY);
      end
   endtask

   task automatic read_all_empty(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         bus.raddrTop = AW'(a); bus.raddrPair = AW'(a);
         step();
         chk({tag, "_top"}, bus.rTop, ENTRY_EMPTY);
         chk({tag, "_l"}, bus.rBotL, ENTRY_EMPTY);
         chk({tag, "_r"}, bus.rBotR, ENTRY_EMPTY);
      end
      idle();
   endtask

   initial begin
      entry_t E, A, B, C, D, F;
      E = ENTRY_EMPTY;
      A = mk(8'd2, 16'd5, 16'd9);
      B = mk(8'd1, 16'd7, 16'd1);
      C = mk(8'd3, 16'd2, 16'd4);
      D = mk(8'd4, 16'd11, 16'd12);
      F = mk(8'd6, 16'd33, 16'd44);

      vecs[0] = mv(0, 0, 0, E, 0, 1, E, E, E, 1);
      vecs[1] = mv(0, 0, 0, E, 3, 2, E, E, E, 1);
      vecs[2] = mv(0, 1, 2, A, 0, 0, E, E, E, 1);
      vecs[3] = mv(0, 0, 0, E, 2, 3, A, A, E, 1);
      vecs[4] = mv(0, 1, 1, B, 1, 0, B, E, B, 1);
      vecs[5] = mv(0, 0, 0, E, 1, 1, B, E, B, 1);
      vecs[6] = mv(0, 1, 0, C, 3, 1, E, C, B, 1);
      vecs[7] = mv(0, 1, 3, D, 3, 2, D, A, D, 1);
      vecs[8] = mv(0, 0, 0, E, 0, 3, C, A, D, 1);
      vecs[9] = mv(1, 1, 0, F, 0, 0, C, C, B, 0);

      // Reset state
      rst_n = 1'b0;
      idle();
      step(); step();
      chk1("rst_ready", bus.ready, 1'b0);
      chk1("rst_err", bus.err, 1'b0);
      chk("rst_rtop", bus.rTop, E);
      chk("rst_rbotl", bus.rBotL, E);
      chk("rst_rbotr", bus.rBotR, E);

      // Sweep with an early write on the second cycle
      rst_n = 1'b1;
      step();
      chk1("sw1_ready", bus.ready, 1'b0);
      bus.wenTop = 1'b1; bus.wraddrTop = 2'd1; bus.wData = A; bus.raddrTop = 2'd1;
      step();
      idle();
      chk1("sw2_err", bus.err, 1'b1);
      chk1("sw2_ready", bus.ready, 1'b0);
      chk("sw2_rtop", bus.rTop, E);
      step();
      chk1("sw3_ready", bus.ready, 1'b0);
      step();
      chk1("sw4_ready", bus.ready, 1'b1);

      // RUN vectors, ending with clr plus same-cycle write
      for (int i = 0; i < 10; i++) begin
         bus.clr = vecs[i].clr; bus.wenTop = vecs[i].wen; bus.wraddrTop = vecs[i].waddr;
         bus.wData = vecs[i].wdata; bus.raddrTop = vecs[i].raddr; bus.raddrPair = vecs[i].paddr;
         step();
         chk($sformatf("v%0d_top", i), bus.rTop, vecs[i].exp_top);
         chk($sformatf("v%0d_l", i), bus.rBotL, vecs[i].exp_l);
         chk($sformatf("v%0d_r", i), bus.rBotR, vecs[i].exp_r);
         chk1($sformatf("v%0d_ready", i), bus.ready, vecs[i].exp_ready);
      end
      idle();
      for (int i = 1; i <= DEPTH; i++) begin
         if (i > 1) step();
         if (i < DEPTH) chk1("clr_ready_low", bus.ready, 1'b0);
      end
      step();
      chk1("clr_ready_high", bus.ready, 1'b1);
      read_all_empty("clr_rd");
      chk1("err_sticky", bus.err, 1'b1);

      // Mid-sweep reset at sweep_ptr==2
      bus.clr = 1'b1;
      step();
      idle();
      step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk1("async_ready", bus.ready, 1'b0);
      chk1("async_err", bus.err, 1'b0);
      step();
      rst_n = 1'b1;
      sweep_wait("rs");

      // Fill, then clr with a same-cycle write: sweep, no err
      for (int a = 0; a < DEPTH; a++) begin
         bus.wenTop = 1'b1; bus.wraddrTop = AW'(a); bus.wData = mk(8'(a), 16'(a), 16'(a + 1));
         step();
      end
      bus.clr = 1'b1; bus.wenTop = 1'b1; bus.wraddrTop = 2'd2; bus.wData = F;
      step();
      idle();
      chk1("clr2_ready", bus.ready, 1'b0);
      chk1("clr2_err", bus.err, 1'b0);
      sweep_wait("clr2");
      read_all_empty("clr2_rd");
      chk1("clr2_err_end", bus.err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pheap_lvl_mem.md
Name: pheap_lvl_mem

Overview:
- Storage responder for one pheap level (LEVEL >= 2). Answers the per-level protocol that level managers initiate.
- Serves two requesters:
  - the top port: this level's own manager reads and writes its node;
  - the pair port: the manager one level up reads both children of its node in one access.
- Performs the post-reset invalidate sweep, so managers never see uninitialised entries.
- One instance per level, between adjacent level managers in the pheap pipeline.

Parameters:
- LEVEL, 2, heap level served. DEPTH = 2**(LEVEL-1) entries; AW = LEVEL-1 address bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous soft clear; restarts the sweep.
- raddrTop  in  AW  top-port read address.
- rTop  out  entry_t  top-port read data.
- wenTop  in  1  top-port write enable.
- wraddrTop  in  AW  top-port write address.
- wData  in  entry_t  top-port write data.
- raddrPair  in  AW  pair read address. Bit 0 is ignored; the pair is {addr[AW-1:1],0} and {addr[AW-1:1],1}.
- rBotL  out  entry_t  even (left) child.
- rBotR  out  entry_t  odd (right) child.
- ready  out  1  sweep complete; accesses are honoured.
- err  out  1  sticky: a write arrived while not ready.

Behaviour:
- Storage is an inferred RAM with no reset. Control flops (state, sweep counter, output registers, err) reset asynchronously on rst_n low.
- Reset values: state=CLEAR, sweep_ptr=0, ready=0, err=0, rTop/rBotL/rBotR=ENTRY_EMPTY.
- FSM CLEAR:
  - Each cycle writes ENTRY_EMPTY to mem[sweep_ptr] (active=0, capacity=0, kv=KV_EMPTY).
  - sweep_ptr increments each cycle.
  - At sweep_ptr==DEPTH-1, moves to RUN.
  - Takes exactly DEPTH cycles after rst_n rises; ready rises the cycle after the last clear write.
- FSM RUN:
  - ready=1.
  - clr=1 moves to CLEAR with sweep_ptr=0; ready drops the next cycle.
  - clr has priority over any same-cycle write; that write is dropped and err is not set.
- Read latency is 1 cycle on both ports. Addresses sampled at edge N give data valid after edge N, matching the manager's READ_MEM -> SET_OUT spacing.
- Reads while not ready return ENTRY_EMPTY.
- Write path:
  - wenTop=1 in RUN writes wData at wraddrTop at the edge.
  - wenTop=1 while not ready (and clr low): write ignored, err<=1 (cleared only by rst_n).
- Collisions, write-first: if a top write and a read (either port) target the same entry in the same cycle, the registered read returns wData, not the old content. Each pair half is forwarded independently.
- Top read and pair read may target any addresses simultaneously; they do not conflict.
- No back-pressure: every RUN access completes; there is no busy stall.
- rst_n assertion mid-sweep or mid-RUN: the FSM returns to CLEAR immediately and the full sweep restarts. RAM contents are undefined until the sweep passes each address.
- Address ports are exactly AW bits wide, so out-of-range addresses cannot occur.

Decomposition:
- entry_t, kv_t, ENTRY_EMPTY, KV_EMPTY and LEVELS come from pheapTypes/pq_pkg.
- Add to pheapTypes:
  - mem_state_t {CLEAR, RUN};
  - a function pair_base(addr) that clears bit 0.
- One sub-module, pheap_ram_2r1w: plain 2-read/1-write synchronous RAM, no reset. The pair port is implemented as two read ports on the even and odd halves.
- Forwarding, sweep and err logic live in pheap_lvl_mem.

Test Plan (LEVEL=3, DEPTH=4):
- Release rst_n at cycle 0 -> ready low for cycles 1-4, high from cycle 5. Reads during cycles 1-4 give ENTRY_EMPTY; all 4 entries then read active=0.
- RUN: write {active=1, cap=2, kv=(5,9)} at addr 2, then raddrTop=2 -> rTop = that entry one cycle later. raddrPair=3 -> rBotL = addr2 entry, rBotR = addr3 ENTRY_EMPTY.
- Same cycle: wenTop at addr 1 with kv=(7,1), raddrTop=1, raddrPair=0 -> next cycle rTop.kv=(7,1) and rBotR.kv=(7,1); rBotL = old addr0.
- Write at cycle 2 of the sweep -> err=1 and stays 1 through RUN and clr. After the sweep, that address reads inactive.
- Fill all 4 entries, pulse clr with a same-cycle wenTop -> ready low for 4 cycles, all entries inactive, err remains 0.
- Drop rst_n mid-sweep (sweep_ptr=2) for 1 cycle -> sweep restarts at 0; ready rises 4 cycles after rst_n releases.
